eth_tx_noc_in_ctrl: RTL and testbench

- Control FSM for the Ethernet TX tile's NoC-input datapath.
- Accepts one NoC message per frame: header flit, then Ethernet metadata flit, then payload flits.
- Sequences the datapath's store/init/decrement strobes and hands the frame to the tostream stage: a header handshake first, then a data-flit stream.
- Keeps frame and backpressure counters for tile statistics.

---
 rtl/eth_tx_noc_in_ctrl_pkg.sv | 11 +
 rtl/eth_tx_noc_in_ctrl_stat_cnt.sv | 19 +
 rtl/eth_tx_noc_in_ctrl.sv | 111 +++++++++++
 tb/tb_eth_tx_noc_in_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_noc_in_ctrl_pkg.sv
// Shared definitions for the Ethernet TX tile: NoC-input controller state encoding.
package eth_tx_tile_defs;

    typedef enum logic [1:0] {
        READY   = 2'd0,
        META    = 2'd1,
        HDR_OUT = 2'd2,
        DATA    = 2'd3
    } eth_tx_noc_in_state_e;

endpackage

// File: rtl/eth_tx_noc_in_ctrl_stat_cnt.sv
// Wrapping statistics counter with synchronous reset and increment enable.
module eth_tx_stat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             incr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (incr) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/eth_tx_noc_in_ctrl.sv
// NoC-input control FSM for the Ethernet TX tile: header, metadata, then payload
// flits, handed to the tostream stage as a header handshake and a data stream.
module eth_tx_noc_in_ctrl
    import eth_tx_tile_defs::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             noc0_ctovr_eth_tx_in_val,
    output logic             eth_tx_in_noc0_ctovr_rdy,
    output logic             eth_tx_in_eth_tostream_hdr_val,
    input  logic             eth_tostream_eth_tx_in_hdr_rdy,
    output logic             eth_tx_in_eth_tostream_data_val,
    input  logic             eth_tostream_eth_tx_in_data_rdy,
    output logic             ctrl_datap_store_hdr_flit,
    output logic             ctrl_datap_store_meta_flit,
    output logic             ctrl_datap_init_num_flits,
    output logic             ctrl_datap_decr_num_flits,
    input  logic             datap_ctrl_last_flit,
    output logic [CNT_W-1:0] stat_frames_sent,
    output logic [CNT_W-1:0] stat_data_stall_cycles,
    output logic             ctrl_busy
);

    // Handshakes: a transfer happens on a cycle where both val and rdy are 1;
    // val never waits on rdy, and in DATA the NoC handshake is the tostream one.
    eth_tx_noc_in_state_e state;
    logic                 no_payload;
    logic                 frame_done;
    logic                 stall_cycle;

    logic val;
    logic data_beat;
    assign val       = noc0_ctovr_eth_tx_in_val;
    assign data_beat = (state == DATA) && val && eth_tostream_eth_tx_in_data_rdy;

    always_comb begin
        eth_tx_in_noc0_ctovr_rdy        = 1'b0;
        eth_tx_in_eth_tostream_hdr_val  = 1'b0;
        eth_tx_in_eth_tostream_data_val = 1'b0;
        ctrl_datap_store_hdr_flit       = 1'b0;
        ctrl_datap_store_meta_flit      = 1'b0;
        ctrl_datap_init_num_flits       = 1'b0;
        ctrl_datap_decr_num_flits       = 1'b0;
        case (state)
            READY: begin
                eth_tx_in_noc0_ctovr_rdy  = 1'b1;
                ctrl_datap_store_hdr_flit = val;
                ctrl_datap_init_num_flits = val;
            end
            META: begin
                eth_tx_in_noc0_ctovr_rdy   = 1'b1;
                ctrl_datap_store_meta_flit = val;
                ctrl_datap_decr_num_flits  = val;
            end
            HDR_OUT: begin
                eth_tx_in_eth_tostream_hdr_val = 1'b1;
            end
            DATA: begin
                eth_tx_in_eth_tostream_data_val = val;
                eth_tx_in_noc0_ctovr_rdy        = eth_tostream_eth_tx_in_data_rdy;
                ctrl_datap_decr_num_flits       = data_beat;
            end
            default: ;
        endcase
    end

    assign frame_done  = ((state == HDR_OUT) && eth_tostream_eth_tx_in_hdr_rdy && no_payload)
                       || (data_beat && datap_ctrl_last_flit);
    assign stall_cycle = (state == DATA) && val && !eth_tostream_eth_tx_in_data_rdy;
    assign ctrl_busy   = (state != READY);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= READY;
            no_payload <= 1'b0;
        end else begin
            case (state)
                READY: if (val) state <= META;
                META: begin
                    if (val) begin
                        // Counter reads 1 here only when the message is metadata alone.
                        no_payload <= datap_ctrl_last_flit;
                        state      <= HDR_OUT;
                    end
                end
                HDR_OUT: begin
                    if (eth_tostream_eth_tx_in_hdr_rdy) state <= no_payload ? READY : DATA;
                end
                DATA: if (data_beat && datap_ctrl_last_flit) state <= READY;
                default: state <= READY;
            endcase
        end
    end

    eth_tx_stat_cnt #(.CNT_W(CNT_W)) u_frames_cnt (
        .clk   (clk),
        .rst   (rst),
        .incr  (frame_done),
        .count (stat_frames_sent)
    );

    eth_tx_stat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .incr  (stall_cycle),
        .count (stat_data_stall_cycles)
    );

endmodule

// File: tb/tb_eth_tx_noc_in_ctrl.sv
// Bench for eth_tx_noc_in_ctrl: frame-schedule reference model plus a datapath counter model.
module tb_eth_tx_noc_in_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        noc_val, noc_rdy, hdr_val, hdr_rdy, data_val, data_rdy;
    logic        st_hdr, st_meta, init_n, decr_n, last_flit, busy;
    logic [31:0] frames, stalls;

    int n_checks = 0;
    int n_errors = 0;
    int exp_frames = 0;
    int exp_stalls = 0;
    int exp_beats  = 0;
    int dp_cnt;
    int dp_len = 0;
    int mon_beats;

    always #5 clk = ~clk;

    eth_tx_noc_in_ctrl #(.CNT_W(32)) dut (
        .clk                             (clk),
        .rst                             (rst),
        .noc0_ctovr_eth_tx_in_val        (noc_val),
        .eth_tx_in_noc0_ctovr_rdy        (noc_rdy),
        .eth_tx_in_eth_tostream_hdr_val  (hdr_val),
        .eth_tostream_eth_tx_in_hdr_rdy  (hdr_rdy),
        .eth_tx_in_eth_tostream_data_val (data_val),
        .eth_tostream_eth_tx_in_data_rdy (data_rdy),
        .ctrl_datap_store_hdr_flit       (st_hdr),
        .ctrl_datap_store_meta_flit      (st_meta),
        .ctrl_datap_init_num_flits       (init_n),
        .ctrl_datap_decr_num_flits       (decr_n),
        .datap_ctrl_last_flit            (last_flit),
        .stat_frames_sent                (frames),
        .stat_data_stall_cycles          (stalls),
        .ctrl_busy                       (busy)
    );

    // Datapath flit-counter model, loaded with msg_len (meta + payload flits).
    always @(posedge clk) begin
        if (rst) dp_cnt <= 0;
        else if (init_n) dp_cnt <= dp_len;
        else if (decr_n) dp_cnt <= dp_cnt - 1;
    end
    assign last_flit = (dp_cnt == 1);

    always @(posedge clk) begin
        if (rst) mon_beats <= 0;
        else if (data_val && data_rdy) mon_beats <= mon_beats + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Output order: {noc_rdy, hdr_val, data_val, st_hdr, st_meta, init, decr, busy}
    task automatic step(input string tag, input logic v, input logic hr, input logic dr,
                        input logic [7:0] exp_o);
        @(negedge clk);
        noc_val  = v;
        hdr_rdy  = hr;
        data_rdy = dr;
        #1;
        chk(tag, {24'b0, noc_rdy, hdr_val, data_val, st_hdr, st_meta, init_n, decr_n, busy},
            {24'b0, exp_o});
        if (decr_n) chk({tag, "_dp_cnt_nonzero"}, {31'b0, dp_cnt != 0}, 32'd1);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'b1000_0000);
    endtask

    task automatic check_stats(input string tag);
        chk({tag, "_frames"}, frames, 32'(exp_frames));
        chk({tag, "_stalls"}, stalls, 32'(exp_stalls));
        chk({tag, "_beats"}, 32'(mon_beats), 32'(exp_beats));
    endtask

    // vmode: 0 val always, 1 alternating, 2 random. rmode: 0 rdy always, 1 random.
    task automatic run_frame(input int len, input int hdr_stall, input int stall_at,
                             input int stall_len, input int vmode, input int rmode,
                             input int abort_after);
        int   done, cyc, stall_left;
        logic v, r;
        dp_len = len;
        step("hdr_flit", 1'b1, 1'b0, 1'b0, 8'b1001_0100);
        step("meta_flit", 1'b1, 1'b0, 1'b0, 8'b1000_1011);
        for (int h = 0; h <= hdr_stall; h++) begin
            step("hdr_out", 1'($urandom_range(0, 1)), h == hdr_stall, 1'($urandom_range(0, 1)),
                 8'b0100_0001);
        end
        done       = 0;
        cyc        = 0;
        stall_left = stall_len;
        while (done < len - 1 && cyc < 200 && done != abort_after) begin
            v = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            if (done == stall_at && stall_left > 0) begin
                v = 1'b1;
                r = 1'b0;
                stall_left--;
            end else begin
                r = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            step("data", v, 1'b0, r, {r, 1'b0, v, 3'b000, v & r, 1'b1});
            if (v && !r) exp_stalls++;
            if (v && r) begin
                done++;
                exp_beats++;
            end
            cyc++;
        end
        if (done != abort_after) begin
            chk("data_beats_in_budget", 32'(done), 32'(len - 1));
            exp_frames++;
        end
    endtask

    initial begin
        rst      = 1'b1;
        noc_val  = 1'b0;
        hdr_rdy  = 1'b0;
        data_rdy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        idle("reset_state");
        check_stats("reset");

        // msg_len=3, downstream always ready
        run_frame(3, 0, -1, 0, 0, 0, -1);
        idle("single_done");
        check_stats("single");

        // msg_len=1, metadata only
        run_frame(1, 0, -1, 0, 0, 0, -1);
        idle("nopay_done");
        check_stats("nopay");

        // msg_len=5 with header and mid-payload backpressure
        run_frame(5, 4, 2, 3, 0, 0, -1);
        idle("bp_done");
        check_stats("bp");
        chk("bp_stall_total", stalls, 32'd3);

        // back-to-back frames with NoC val held high
        run_frame(2, 0, -1, 0, 0, 0, -1);
        run_frame(4, 0, -1, 0, 0, 0, -1);
        idle("b2b_done");
        check_stats("b2b");

        // reset in DATA after 1 of 3 payload beats
        run_frame(4, 0, -1, 0, 0, 0, 1);
        @(negedge clk);
        rst     = 1'b1;
        noc_val = 1'b0;
        @(negedge clk);
        rst        = 1'b0;
        exp_frames = 0;
        exp_stalls = 0;
        exp_beats  = 0;
        #1;
        chk("post_reset_outs",
            {24'b0, noc_rdy, hdr_val, data_val, st_hdr, st_meta, init_n, decr_n, busy},
            {24'b0, 8'b1000_0000});
        check_stats("post_reset");
        run_frame(2, 0, -1, 0, 0, 0, -1);
        idle("after_reset_done");
        check_stats("after_reset");

        // alternating val bubbles with rdy held
        run_frame(6, 1, -1, 0, 1, 0, -1);
        idle("bubble_done");
        check_stats("bubble");
        chk("bubble_no_stall", stalls, 32'd0);

        // randomized frames
        for (int f = 0; f < 25; f++) begin
            run_frame($urandom_range(1, 8), $urandom_range(0, 3), -1, 0, 2, 1, -1);
            if ($urandom_range(0, 1) == 1) idle("rand_gap");
        end
        idle("rand_done");
        check_stats("rand");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
